// File: rtl/dff_chk_pkg.sv
// Shared types for the dff response checker.
// State encoding and default data width.
package dff_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      CHECK = 2'd2,
      HALT  = 2'd3
   } chk_state_t;

   localparam int DFF_WIDTH_DEF = 4;
   localparam int MAX_LATENCY   = 8;

endpackage

// File: rtl/dff_exp_pipe.sv
// Expected-value delay line for the dff checker.
// Data shifts on load; flush clears only the valid bits.
module dff_exp_pipe
   import dff_chk_pkg::*;
#(
   parameter int WIDTH   = DFF_WIDTH_DEF,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] tail,
   output logic             tail_v,
   output logic             pre_v
);

   logic [WIDTH-1:0] stage [LATENCY];
   logic [LATENCY-1:0] v;

   // shift sampled stimulus and its valid bit down the line
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage <= '{default: '0};
         v     <= '0;
      end else if (flush) begin
         v <= '0;
      end else if (load) begin
         stage[0] <= d;
         v[0]     <= 1'b1;
         for (int i = 1; i < LATENCY; i++) begin
            stage[i] <= stage[i-1];
            v[i]     <= v[i-1];
         end
      end
   end

   assign tail   = stage[LATENCY-1];
   assign tail_v = v[LATENCY-1];

   // one stage before the tail: the tail is valid after the next load
   generate
      if (LATENCY > 1) begin : g_pre
         assign pre_v = v[LATENCY-2];
      end else begin : g_pre1
         assign pre_v = 1'b1;
      end
   endgenerate

endmodule

// File: rtl/dff_resp_checker.sv
// Response checker for a dff DUT: predicts q from d,
// flags mismatches and keeps saturating counters.
module dff_resp_checker
   import dff_chk_pkg::*;
#(
   parameter int WIDTH       = DFF_WIDTH_DEF,
   parameter int LATENCY     = 1,
   parameter int ERR_CNT_W   = 8,
   parameter int CHK_CNT_W   = 16,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clear,
   input  logic [WIDTH-1:0]     d_obs,
   input  logic [WIDTH-1:0]     q_obs,
   output logic [WIDTH-1:0]     exp_q,
   output logic                 mismatch,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [CHK_CNT_W-1:0] chk_cnt,
   output logic [1:0]           state
);

   chk_state_t cur, nxt;
   logic [WIDTH-1:0] tail;
   logic tail_v, pre_v, flush;
   logic compare, bad;

   assign flush = clear || !en;

   dff_exp_pipe #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY)
   ) u_pipe (
      .clk    (clk),
      .reset  (reset),
      .load   (en),
      .flush  (flush),
      .d      (d_obs),
      .tail   (tail),
      .tail_v (tail_v),
      .pre_v  (pre_v)
   );

   // X/Z on q_obs must count as a failure, hence the case inequality
   assign compare = en && !clear && tail_v &&
                    (cur == FILL || cur == CHECK);
   assign bad     = compare && (q_obs !== tail);

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cur <= IDLE;
      else        cur <= nxt;
   end

   // next-state: HALT is left only through clear or reset
   always_comb begin
      nxt = cur;
      unique case (cur)
         IDLE:  if (en) nxt = FILL;
         FILL: begin
            if (!en)                     nxt = IDLE;
            else if (bad && STOP_ON_ERR) nxt = HALT;
            else if (pre_v)              nxt = CHECK;
         end
         CHECK: begin
            if (!en)                     nxt = IDLE;
            else if (bad && STOP_ON_ERR) nxt = HALT;
         end
         HALT:  nxt = HALT;
      endcase
      if (clear) nxt = IDLE;
   end

   // compare results and saturating counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_q    <= '0;
         mismatch <= 1'b0;
         err_cnt  <= '0;
         chk_cnt  <= '0;
      end else if (clear) begin
         mismatch <= 1'b0;
         err_cnt  <= '0;
         chk_cnt  <= '0;
      end else begin
         mismatch <= bad;
         if (compare) begin
            exp_q <= tail;
            if (chk_cnt != '1) chk_cnt <= chk_cnt + 1'b1;
            if (bad && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
         end
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_dff_resp_checker.sv
// Bench for dff_resp_checker: four parameter variants
// share stimulus and are checked against a history model.
module tb_dff_resp_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, en, clear;
   logic [3:0] d_obs, q_obs;

   logic [3:0]  eq0, eq1, eq2, eq3;
   logic        mi0, mi1, mi2, mi3;
   logic [7:0]  er0, er1, er3;
   logic [1:0]  er2;
   logic [15:0] ck0, ck1, ck2, ck3;
   logic [1:0]  st0, st1, st2, st3;

   dff_resp_checker #(.WIDTH(4), .LATENCY(1)) u0 (
      .clk(clk), .reset(reset), .en(en), .clear(clear),
      .d_obs(d_obs), .q_obs(q_obs), .exp_q(eq0),
      .mismatch(mi0), .err_cnt(er0), .chk_cnt(ck0),
      .state(st0));

   dff_resp_checker #(.WIDTH(4), .STOP_ON_ERR(1'b1)) u1 (
      .clk(clk), .reset(reset), .en(en), .clear(clear),
      .d_obs(d_obs), .q_obs(q_obs), .exp_q(eq1),
      .mismatch(mi1), .err_cnt(er1), .chk_cnt(ck1),
      .state(st1));

   dff_resp_checker #(.WIDTH(4), .ERR_CNT_W(2)) u2 (
      .clk(clk), .reset(reset), .en(en), .clear(clear),
      .d_obs(d_obs), .q_obs(q_obs), .exp_q(eq2),
      .mismatch(mi2), .err_cnt(er2), .chk_cnt(ck2),
      .state(st2));

   dff_resp_checker #(.WIDTH(4), .LATENCY(3)) u3 (
      .clk(clk), .reset(reset), .en(en), .clear(clear),
      .d_obs(d_obs), .q_obs(q_obs), .exp_q(eq3),
      .mismatch(mi3), .err_cnt(er3), .chk_cnt(ck3),
      .state(st3));

   int n_pass = 0;
   int n_fail = 0;
   int n_tot  = 0;

   function automatic void chk(string tag, logic [31:0] obs,
                               logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endfunction

   // reference: run length of enabled edges plus d history
   int         lat  [4] = '{1, 1, 1, 3};
   bit         stp  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   int         emax [4] = '{255, 255, 3, 255};
   logic [3:0] m_exp [4];
   bit         m_mis [4];
   int         m_err [4];
   int         m_chk [4];
   bit         m_halt[4];
   logic [3:0] hist [8];
   int         run;
   logic [3:0] prev;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_exp[i] = '0; m_mis[i] = 0; m_err[i] = 0;
         m_chk[i] = 0;  m_halt[i] = 0;
      end
      run = 0;
   endtask

   task automatic model_edge(input logic e, input logic c,
                             input logic [3:0] d,
                             input logic [3:0] q);
      for (int i = 0; i < 4; i++) begin
         m_mis[i] = 0;
         if (c) begin
            m_err[i] = 0; m_chk[i] = 0; m_halt[i] = 0;
         end else if (!m_halt[i] && e && run >= lat[i]) begin
            m_exp[i] = hist[lat[i]-1];
            if (m_chk[i] < 65535) m_chk[i]++;
            if (q !== hist[lat[i]-1]) begin
               m_mis[i] = 1;
               if (m_err[i] < emax[i]) m_err[i]++;
               if (stp[i]) m_halt[i] = 1;
            end
         end
      end
      if (c || !e) run = 0;
      else begin
         for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = d;
         if (run < 100) run++;
      end
   endtask

   // HALT if stopped, IDLE with no run, CHECK once tail is
   // reachable (at least one edge spent filling), else FILL
   function automatic int m_state(int i);
      int need;
      need = (lat[i] < 2) ? 2 : lat[i];
      if (m_halt[i])       return 3;
      if (run == 0)        return 0;
      if (run >= need)     return 2;
      return 1;
   endfunction

   function automatic void check_inst(int i, logic [3:0] eq,
      logic mi, logic [31:0] er, logic [31:0] ck, logic [1:0] st);
      chk($sformatf("u%0d.exp_q", i), 32'(eq), 32'(m_exp[i]));
      chk($sformatf("u%0d.mismatch", i), 32'(mi), 32'(m_mis[i]));
      chk($sformatf("u%0d.err_cnt", i), er, 32'(m_err[i]));
      chk($sformatf("u%0d.chk_cnt", i), ck, 32'(m_chk[i]));
      chk($sformatf("u%0d.state", i), 32'(st), 32'(m_state(i)));
   endfunction

   function automatic void check_all();
      check_inst(0, eq0, mi0, 32'(er0), 32'(ck0), st0);
      check_inst(1, eq1, mi1, 32'(er1), 32'(ck1), st1);
      check_inst(2, eq2, mi2, 32'(er2), 32'(ck2), st2);
      check_inst(3, eq3, mi3, 32'(er3), 32'(ck3), st3);
   endfunction

   // drive at negedge, clock once, check at next negedge
   task automatic step(input logic e, input logic c,
                       input logic [3:0] d, input logic [3:0] q);
      en = e; clear = c; d_obs = d; q_obs = q;
      model_edge(e, c, d, q);
      @(posedge clk);
      @(negedge clk);
      check_all();
      prev = d;
   endtask

   task automatic step_ok(input logic [3:0] d);
      step(1'b1, 1'b0, d, prev);
   endtask

   int         c0, pulses, p;
   logic       re, rc;
   logic [3:0] rd, rq;

   initial begin
      reset = 1'b0; en = 1'b0; clear = 1'b0;
      d_obs = '0; q_obs = '0; prev = '0;
      for (int j = 0; j < 8; j++) hist[j] = '0;
      model_reset();
      @(negedge clk);
      check_all();
      reset = 1'b1;

      // correct responses, then a wrong q after d=6
      step_ok(4'h3);
      step_ok(4'h5);
      step_ok(4'hA);
      step_ok(4'hF);
      step_ok(4'h6);
      chk("t1.chk_cnt", 32'(ck0), 4);
      chk("t1.err_cnt", 32'(er0), 0);
      chk("t1.state", 32'(st0), 2);
      step(1'b1, 1'b0, 4'h2, 4'h7);
      chk("t2.mismatch", 32'(mi0), 1);
      chk("t2.exp_q", 32'(eq0), 6);
      chk("t2.err_cnt", 32'(er0), 1);
      step_ok(4'h5);
      chk("t2.pulse_end", 32'(mi0), 0);

      // stop-on-error instance stays frozen
      for (int k = 0; k < 9; k++) step_ok(4'($urandom));
      chk("t3.halt", 32'(st1), 3);
      chk("t3.err_cnt", 32'(er1), 1);
      chk("t3.chk_cnt", 32'(ck1), 5);
      step(1'b1, 1'b1, 4'h0, prev);
      chk("t3.clr_state", 32'(st1), 0);
      chk("t3.clr_chk", 32'(ck1), 0);

      // enable dropped with bad q: nothing counted
      step_ok(4'h4);
      step_ok(4'h7);
      step_ok(4'h8);
      c0 = int'(ck0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'h1, 4'h9);
      chk("t4.hold_chk", 32'(ck0), 32'(c0));
      chk("t4.idle", 32'(st0), 0);
      step(1'b1, 1'b0, 4'h3, 4'h9);
      chk("t4.fill", 32'(st0), 1);
      chk("t4.no_cmp", 32'(ck0), 32'(c0));
      step_ok(4'h5);
      chk("t4.first_cmp", 32'(ck0), 32'(c0 + 1));

      // narrow error counter saturates while pulses continue
      step(1'b1, 1'b1, 4'h0, prev);
      pulses = 0;
      for (int k = 0; k < 7; k++) begin
         step(1'b1, 1'b0, 4'h1, 4'h0);
         if (mi2) pulses++;
      end
      chk("t5.pulses", 32'(pulses), 6);
      chk("t5.err_sat", 32'(er2), 3);

      // undefined q counts as a failure
      step(1'b1, 1'b0, 4'h2, 4'bx);
      chk("t5.xq", 32'(mi0), 1);

      // asynchronous reset between edges
      step(1'b1, 1'b1, 4'h0, prev);
      step_ok(4'h1);
      step_ok(4'h2);
      #2 reset = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b1;
      step_ok(4'h9);
      chk("t6.fill", 32'(st0), 1);
      step_ok(4'hC);
      chk("t6.check", 32'(st0), 2);

      // random traffic
      for (int k = 0; k < 300; k++) begin
         p  = int'($urandom_range(0, 99));
         re = (p >= 10);
         rc = ($urandom_range(0, 39) == 0);
         rd = 4'($urandom);
         rq = ($urandom_range(0, 5) == 0) ? 4'($urandom) : prev;
         if ($urandom_range(0, 49) == 0) rq = 4'bx;
         step(re, rc, rd, rq);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
